// File: rtl/fetch_stage_pkg.sv
// Shared constants for the LEGv8 fetch stage: default widths, the canonical
// NOP word and the instruction field bounds used by fetch and branch logic.
package fetch_stage_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

  // Opcode field handed to the decoder
  localparam int OPC_W   = 11;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;

  // Branch immediate fields: imm26 for B/BL, imm19 for CBZ/CBNZ/B.cond
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;

  // ADD XZR, XZR, XZR: architecturally harmless filler for bubbles
  localparam logic [31:0] NOP_INSTR = 32'h8B1F_03FF;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: instruction memory
// port, branch resolution inputs from ID/hazard unit, and the IF/ID outputs.
interface fetch_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  // Hazard and branch-resolution controls
  logic               stall;
  logic               br_taken;
  logic               uncond_br;
  logic               breg_sig;
  logic [ADDR_W-1:0]  reg_target;

  // Instruction memory (combinational read)
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  // Fetch PC and IF/ID pipeline register contents
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               if_id_valid;
  logic [10:0]        opcode;
  logic [ADDR_W-1:0]  link_addr;

  modport master (
    input  stall, br_taken, uncond_br, breg_sig, reg_target, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc, if_id_valid, opcode, link_addr
  );

  modport slave (
    output stall, br_taken, uncond_br, breg_sig, reg_target, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc, if_id_valid, opcode, link_addr
  );

endinterface

// File: rtl/fetch_stage_branch_target_calc.sv
// Branch target generator: sign-extends the word offset of the instruction in
// ID, adds it to that instruction's PC, or selects an aligned register target
// for BR. Purely combinational so a future predictor can reuse it.
module branch_target_calc
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [IMM26_MSB:IMM26_LSB] imm_field,
  input  logic [ADDR_W-1:0]          base_pc,
  input  logic                       uncond_br,
  input  logic                       breg_sig,
  input  logic [ADDR_W-1:0]          reg_target,
  output logic [ADDR_W-1:0]          target
);

  // Word offsets are counted in instructions, hence the shift by 2
  function automatic logic signed [ADDR_W-1:0] word_off26(input logic signed [25:0] imm);
    logic signed [ADDR_W-1:0] ext;
    ext = ADDR_W'(imm);
    return ext <<< 2;
  endfunction

  function automatic logic signed [ADDR_W-1:0] word_off19(input logic signed [18:0] imm);
    logic signed [ADDR_W-1:0] ext;
    ext = ADDR_W'(imm);
    return ext <<< 2;
  endfunction

  // Target select: BR register wins, else PC-relative by immediate size; adds wrap
  always_comb begin
    target = base_pc;
    if (breg_sig) begin
      target = reg_target & ~ADDR_W'(3);
    end else if (uncond_br) begin
      target = base_pc + $unsigned(word_off26(imm_field[IMM26_MSB:IMM26_LSB]));
    end else begin
      target = base_pc + $unsigned(word_off19(imm_field[IMM19_MSB:IMM19_LSB]));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Branches resolve in ID; the instruction fetched in the
// resolving cycle is the delay slot and is either kept or squashed.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter bit                DELAY_SLOT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fif
);

  // Fetch-side state (stage 0)
  logic [ADDR_W-1:0]  pc_p0;
  logic [ADDR_W-1:0]  next_pc_p0;

  // IF/ID register contents (stage 1)
  logic [INSTR_W-1:0] instr_p1;
  logic [ADDR_W-1:0]  pc_p1;
  logic               vld_p1;

  logic [ADDR_W-1:0]  target_p1;
  logic               take_p1;

  branch_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .imm_field  (instr_p1[IMM26_MSB:IMM26_LSB]),
    .base_pc    (pc_p1),
    .uncond_br  (fif.uncond_br),
    .breg_sig   (fif.breg_sig),
    .reg_target (fif.reg_target),
    .target     (target_p1)
  );

  // A bubble never redirects, and a stalled decoder's operands are not trusted
  assign take_p1 = fif.br_taken & vld_p1 & ~fif.stall;

  // Next-PC mux: hold on stall, redirect on a taken branch, otherwise sequential
  always_comb begin
    next_pc_p0 = pc_p0 + ADDR_W'(4);
    if (fif.stall) begin
      next_pc_p0 = pc_p0;
    end else if (take_p1) begin
      next_pc_p0 = target_p1;
    end
  end

  // ---- stage 0 -> stage 1 boundary: PC register ----
  // PC register; reset overrides any redirect resolving in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= next_pc_p0;
    end
  end

  // ---- stage 1 boundary: IF/ID register ----
  // IF/ID register: hold on stall, squash the delay slot when slots are disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else if (!fif.stall) begin
      pc_p1 <= pc_p0;
      if (take_p1 && !DELAY_SLOT) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else begin
        instr_p1 <= fif.imem_rdata;
        vld_p1   <= 1'b1;
      end
    end
  end

  assign fif.imem_addr   = pc_p0;
  assign fif.pc          = pc_p0;
  assign fif.if_id_instr = instr_p1;
  assign fif.if_id_pc    = pc_p1;
  assign fif.if_id_valid = vld_p1;
  assign fif.opcode      = opcode_of(instr_p1);
  assign fif.link_addr   = pc_p1 + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (delay slot kept / squashed) driven with
// identical controls, directed branch scenarios plus randomized traffic checked
// against an instruction-level reference model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam logic [31:0] B_PLUS3   = 32'h1400_0003;  // B #+3 words
  localparam logic [31:0] CBZ_MINUS2 = 32'hB4FF_FFC0; // CBZ X0, #-2 words
  localparam logic [10:0] NOP_OPC   = 11'b10001011000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) if1 ();
  fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) if0 ();

  fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .fif(if1)
  );
  fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .fif(if0)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [63:0]];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model, index 0 = squashing build, 1 = delay-slot build
  logic [63:0] m_pc   [2];
  logic [63:0] m_idpc [2];
  logic [31:0] m_instr[2];
  logic        m_vld  [2];

  task automatic model_step(input logic rst, input logic st, input logic br,
                            input logic unc, input logic breg, input logic [63:0] rt);
    for (int d = 0; d < 2; d++) begin
      logic signed [25:0] i26;
      logic signed [18:0] i19;
      longint             off;
      logic [63:0]        tgt;
      bit                 take;
      if (rst) begin
        m_pc[d] = 64'h0; m_idpc[d] = 64'h0; m_instr[d] = 32'h8B1F_03FF; m_vld[d] = 1'b0;
      end else if (!st) begin
        take = br && m_vld[d];
        i26 = m_instr[d][25:0];
        i19 = m_instr[d][23:5];
        off = unc ? longint'(i26) * 4 : longint'(i19) * 4;
        tgt = breg ? (rt / 4) * 4 : m_idpc[d] + off;
        m_idpc[d] = m_pc[d];
        if (take && d == 0) begin
          m_instr[d] = 32'h8B1F_03FF; m_vld[d] = 1'b0;
        end else begin
          m_instr[d] = word_at(m_pc[d]); m_vld[d] = 1'b1;
        end
        m_pc[d] = take ? tgt : m_pc[d] + 64'd4;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic br,
                       input logic unc, input logic breg, input logic [63:0] rt);
    reset = rst;
    if1.stall = st; if1.br_taken = br; if1.uncond_br = unc; if1.breg_sig = breg; if1.reg_target = rt;
    if0.stall = st; if0.br_taken = br; if0.uncond_br = unc; if0.breg_sig = breg; if0.reg_target = rt;
    model_step(rst, st, br, unc, breg, rt);
    @(posedge clk);
    #1;
    if1.imem_rdata = word_at(if1.imem_addr);
    if0.imem_rdata = word_at(if0.imem_addr);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  // Reset, then run sequentially until the given PC sits in ID
  task automatic run_to(input logic [63:0] idpc);
    int n;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    n = 0;
    while (!(m_vld[1] && m_idpc[1] == idpc) && n < 200) begin
      idle();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL run_to timeout actual_cycles=%0d required<200 target=%h", n, idpc);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", if1.pc); end
    checks++; if (if1.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", if1.if_id_valid); end
    checks++; if (if1.opcode !== NOP_OPC) begin errors++; $display("FAIL reset_opcode got=%b want=%b", if1.opcode, NOP_OPC); end
    checks++; if (if1.if_id_instr !== 32'h8B1F_03FF) begin errors++; $display("FAIL reset_instr got=%h want=8b1f03ff", if1.if_id_instr); end
    checks++; if (if1.if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_idpc got=%h want=0", if1.if_id_pc); end
    checks++; if (if0.if_id_valid !== 1'b0 || if0.pc !== 64'h0) begin errors++; $display("FAIL reset_ds0 got=%b/%h want=0/0", if0.if_id_valid, if0.pc); end
    idle();
    checks++; if (if1.pc !== 64'h4) begin errors++; $display("FAIL release_pc1 got=%h want=4", if1.pc); end
    checks++; if (if1.if_id_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%b want=1", if1.if_id_valid); end
    checks++; if (if1.if_id_instr !== word_at(64'h0)) begin errors++; $display("FAIL release_instr got=%h want=%h", if1.if_id_instr, word_at(64'h0)); end
    idle();
    checks++; if (if1.pc !== 64'h8 || if1.if_id_pc !== 64'h4) begin errors++; $display("FAIL release_pc2 got=%h/%h want=8/4", if1.pc, if1.if_id_pc); end
    checks++; if (if1.link_addr !== 64'h8) begin errors++; $display("FAIL link_addr got=%h want=8", if1.link_addr); end
  endtask

  task automatic test_branch_imm26();
    run_to(64'h10);
    checks++; if (if1.if_id_instr !== B_PLUS3 || if1.pc !== 64'h14) begin errors++; $display("FAIL b_setup got=%h/%h want=%h/14", if1.if_id_instr, if1.pc, B_PLUS3); end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h1C) begin errors++; $display("FAIL b_target got=%h want=1c", if1.pc); end
    checks++; if (if1.if_id_pc !== 64'h14 || if1.if_id_valid !== 1'b1) begin errors++; $display("FAIL b_slot got=%h/%b want=14/1", if1.if_id_pc, if1.if_id_valid); end
    checks++; if (if1.if_id_instr !== word_at(64'h14)) begin errors++; $display("FAIL b_slot_instr got=%h want=%h", if1.if_id_instr, word_at(64'h14)); end
    checks++; if (if0.pc !== 64'h1C || if0.if_id_valid !== 1'b0 || if0.if_id_instr !== 32'h8B1F_03FF) begin
      errors++; $display("FAIL b_squash got=%h/%b/%h want=1c/0/8b1f03ff", if0.pc, if0.if_id_valid, if0.if_id_instr); end
    idle();
    checks++; if (if1.if_id_pc !== 64'h1C || if1.pc !== 64'h20) begin errors++; $display("FAIL b_after got=%h/%h want=1c/20", if1.if_id_pc, if1.pc); end
    checks++; if (if0.if_id_pc !== 64'h1C || if0.if_id_valid !== 1'b1) begin errors++; $display("FAIL b_after_ds0 got=%h/%b want=1c/1", if0.if_id_pc, if0.if_id_valid); end
  endtask

  task automatic test_cbz();
    run_to(64'h40);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h38 || if1.if_id_pc !== 64'h44) begin errors++; $display("FAIL cbz_taken got=%h/%h want=38/44", if1.pc, if1.if_id_pc); end
    run_to(64'h40);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h48 || if1.if_id_pc !== 64'h44) begin errors++; $display("FAIL cbz_not_taken got=%h/%h want=48/44", if1.pc, if1.if_id_pc); end
  endtask

  task automatic test_stall();
    run_to(64'h10);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
      checks++; if (if1.pc !== 64'h14 || if1.if_id_pc !== 64'h10 || if1.if_id_instr !== B_PLUS3) begin
        errors++; $display("FAIL stall_hold%0d got=%h/%h/%h want=14/10/%h", i, if1.pc, if1.if_id_pc, if1.if_id_instr, B_PLUS3); end
      checks++; if (if0.pc !== 64'h14 || if0.if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_ds0 got=%h/%b want=14/1", if0.pc, if0.if_id_valid); end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h1C || if1.if_id_pc !== 64'h14) begin errors++; $display("FAIL stall_release got=%h/%h want=1c/14", if1.pc, if1.if_id_pc); end
  endtask

  task automatic test_breg();
    run_to(64'h8);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1003);
    checks++; if (if1.pc !== 64'h1000 || if1.if_id_valid !== 1'b1) begin errors++; $display("FAIL br_ds1 got=%h/%b want=1000/1", if1.pc, if1.if_id_valid); end
    checks++; if (if0.pc !== 64'h1000 || if0.if_id_valid !== 1'b0 || if0.opcode !== NOP_OPC) begin
      errors++; $display("FAIL br_ds0 got=%h/%b/%b want=1000/0/%b", if0.pc, if0.if_id_valid, if0.opcode, NOP_OPC); end
    // Second taken request: delay-slot build takes it, squashed build has a bubble in ID
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h2000);
    checks++; if (if1.pc !== 64'h2000) begin errors++; $display("FAIL br_ds1_again got=%h want=2000", if1.pc); end
    checks++; if (if0.pc !== 64'h1004 || if0.if_id_pc !== 64'h1000) begin errors++; $display("FAIL bubble_redirect got=%h/%h want=1004/1000", if0.pc, if0.if_id_pc); end
  endtask

  task automatic test_reset_after_branch();
    run_to(64'h10);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checks++; if (if1.pc !== 64'h0 || if1.if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_after_br got=%h/%b want=0/0", if1.pc, if1.if_id_valid); end
    idle();
    checks++; if (if1.pc !== 64'h4 || if1.if_id_pc !== 64'h0) begin errors++; $display("FAIL rst_after_br_release got=%h/%h want=4/0", if1.pc, if1.if_id_pc); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (if1.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL br_top got=%h want=fffffffffffffffc", if1.pc); end
    idle();
    checks++; if (if1.pc !== 64'h0 || if1.if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL pc_wrap got=%h/%h want=0/fffffffffffffffc", if1.pc, if1.if_id_pc); end
    checks++; if (if1.link_addr !== 64'h0) begin errors++; $display("FAIL link_wrap got=%h want=0", if1.link_addr); end
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 400; i++) begin
      logic        rst, st, br, unc, breg;
      logic [63:0] rt;
      rst  = ($urandom % 64) == 0;
      st   = ($urandom % 5) == 0;
      br   = ($urandom % 3) == 0;
      unc  = $urandom % 2;
      breg = ($urandom % 4) == 0;
      rt   = {$urandom, $urandom};
      cycle(rst, st, br, unc, breg, rt);
      checks++;
      if ({if1.pc, if1.imem_addr, if1.if_id_pc, if1.if_id_instr, if1.if_id_valid, if1.opcode, if1.link_addr} !==
          {m_pc[1], m_pc[1], m_idpc[1], m_instr[1], m_vld[1], m_instr[1][31:21], m_idpc[1] + 64'd4}) begin
        errors++;
        $display("FAIL rand_ds1 cyc=%0d got pc=%h idpc=%h instr=%h v=%b want pc=%h idpc=%h instr=%h v=%b",
                 i, if1.pc, if1.if_id_pc, if1.if_id_instr, if1.if_id_valid, m_pc[1], m_idpc[1], m_instr[1], m_vld[1]);
      end
      checks++;
      if ({if0.pc, if0.imem_addr, if0.if_id_pc, if0.if_id_instr, if0.if_id_valid, if0.opcode, if0.link_addr} !==
          {m_pc[0], m_pc[0], m_idpc[0], m_instr[0], m_vld[0], m_instr[0][31:21], m_idpc[0] + 64'd4}) begin
        errors++;
        $display("FAIL rand_ds0 cyc=%0d got pc=%h idpc=%h instr=%h v=%b want pc=%h idpc=%h instr=%h v=%b",
                 i, if0.pc, if0.if_id_pc, if0.if_id_instr, if0.if_id_valid, m_pc[0], m_idpc[0], m_instr[0], m_vld[0]);
      end
      checks++;
      if (if1.pc[1:0] !== 2'b00 || if0.pc[1:0] !== 2'b00) begin
        errors++; $display("FAIL pc_align cyc=%0d got=%b/%b want=00/00", i, if1.pc[1:0], if0.pc[1:0]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[64'h10] = B_PLUS3;
    mem[64'h40] = CBZ_MINUS2;
    reset = 1'b1;
    if1.stall = 1'b0; if1.br_taken = 1'b0; if1.uncond_br = 1'b0; if1.breg_sig = 1'b0; if1.reg_target = '0;
    if0.stall = 1'b0; if0.br_taken = 1'b0; if0.uncond_br = 1'b0; if0.breg_sig = 1'b0; if0.reg_target = '0;
    if1.imem_rdata = '0;
    if0.imem_rdata = '0;
    test_reset();
    test_branch_imm26();
    test_cbz();
    test_stall();
    test_breg();
    test_reset_after_branch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
